// File: rtl/encoder8to3_seq.sv
// Sequential 8-to-3 encoder: latches request pulses into a pending vector and
// serves one binary index per accept on a valid/ready port, fixed or rotating priority.
module encoder8to3_seq #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] y,
  output logic       valid,
  output logic [3:0] npend,
  output logic       dup
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state, state_next;
  logic [7:0] pending, pending_next, clr, cand;
  logic [2:0] rr_ptr, rr_ptr_next, ptr_eff, sel, y_next;
  logic       accept, has_cand, valid_next, dup_next;
  logic [3:0] npend_next;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) cnt = cnt + 4'(v[i]);
    return cnt;
  endfunction

  // Accepting the presented index retires its pending bit this edge
  always_comb begin
    accept = valid & ready;
    clr = accept ? (8'b0000_0001 << y) : 8'b0;
    cand = pending & ~clr;
    has_cand = |cand;
    ptr_eff = accept ? 3'(y + 3'd1) : rr_ptr;
    pending_next = cand | (ena ? req : 8'b0);
    dup_next = ena & (|(req & pending & ~clr));
    npend_next = popcount8(pending_next);
  end

  // Candidate choice looks only at registered pending, never at this edge's req
  always_comb begin
    logic       found;
    logic [2:0] idx;
    sel = 3'd0;
    found = 1'b0;
    idx = 3'd0;
    if (ROUND_ROBIN) begin
      for (int k = 0; k < 8; k++) begin
        idx = ptr_eff + 3'(k);
        if (!found && cand[idx]) begin
          sel = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (cand[i]) sel = 3'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    y_next = y;
    valid_next = valid;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (has_cand) begin
          y_next = sel;
          valid_next = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) begin
          rr_ptr_next = 3'(y + 3'd1);
          if (has_cand) begin
            y_next = sel;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= 8'b0;
      y <= 3'd0;
      valid <= 1'b0;
      npend <= 4'd0;
      dup <= 1'b0;
      rr_ptr <= 3'd0;
    end else begin
      state <= state_next;
      pending <= pending_next;
      y <= y_next;
      valid <= valid_next;
      npend <= npend_next;
      dup <= dup_next;
      rr_ptr <= rr_ptr_next;
    end
  end

endmodule
